// File: rtl/edge_frame_writer.sv
// Edge-count frame writer: counts large steps between consecutive samples of a frame
// and hands each frame's count to a register file over a strobe/acknowledge handshake.
module edge_frame_writer #(
   parameter int unsigned POPSIZE     = 100,
   parameter int unsigned FRAME_SIZE  = 20,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned EDGE_THRESH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [DATA_WIDTH-1:0]     sample_in,
   input  logic                      sample_vld,
   output logic [DATA_WIDTH-1:0]     data_in,
   output logic                      data_rdy,
   input  logic                      new_data,
   output logic [$clog2(POPSIZE):0]  frame_cnt,
   output logic                      pop_full,
   output logic                      overflow
);
   localparam int unsigned CNT_W  = $clog2(POPSIZE) + 1;
   localparam int unsigned SAMP_W = $clog2(FRAME_SIZE) + 1;
   localparam int unsigned DIFF_W = DATA_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} state_t;

   state_t                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  prev_q, prev_d;
   logic [SAMP_W-1:0]      samp_q, samp_d;
   logic [DATA_WIDTH-1:0]  edge_q, edge_d;
   logic [DATA_WIDTH-1:0]  data_in_d;
   logic                   data_rdy_d;
   logic [CNT_W-1:0]       frame_cnt_d;
   logic                   pop_full_d;
   logic                   overflow_d;

   logic                   accept_c;
   logic                   is_edge_c;
   logic                   frame_done_c;
   logic                   last_ack_c;
   logic [DIFF_W-1:0]      diff_c;
   logic [DATA_WIDTH-1:0]  edge_sum_c;

   // Per-sample edge detection; the sum includes the current sample so the
   // completing sample's edge lands in the frame count.
   assign accept_c     = sample_vld & enable & ~pop_full;
   assign diff_c       = (sample_in >= prev_q) ? DIFF_W'(sample_in) - DIFF_W'(prev_q)
                                               : DIFF_W'(prev_q) - DIFF_W'(sample_in);
   assign is_edge_c    = (samp_q != '0) && (diff_c >= DIFF_W'(EDGE_THRESH));
   assign edge_sum_c   = (is_edge_c && (edge_q != '1)) ? edge_q + DATA_WIDTH'(1) : edge_q;
   assign frame_done_c = accept_c && (samp_q == SAMP_W'(FRAME_SIZE - 1));
   assign last_ack_c   = new_data && (state_q != IDLE) && (frame_cnt == CNT_W'(POPSIZE - 1));

   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      samp_d      = samp_q;
      edge_d      = edge_q;
      data_in_d   = data_in;
      data_rdy_d  = 1'b0;
      frame_cnt_d = frame_cnt;
      pop_full_d  = pop_full;
      overflow_d  = overflow;

      if (accept_c) begin
         if (frame_done_c) begin
            prev_d = '0;
            samp_d = '0;
            edge_d = '0;
         end else begin
            prev_d = sample_in;
            samp_d = samp_q + SAMP_W'(1);
            edge_d = edge_sum_c;
         end
      end

      // A frame finishing on the final population ack is dropped, not sent.
      case (state_q)
         IDLE: begin
            if (frame_done_c) begin
               state_d    = SEND;
               data_in_d  = edge_sum_c;
               data_rdy_d = 1'b1;
            end
         end
         SEND, WAIT_ACK: begin
            if (new_data) begin
               frame_cnt_d = frame_cnt + CNT_W'(1);
               pop_full_d  = last_ack_c;
               if (frame_done_c && !last_ack_c) begin
                  state_d    = SEND;
                  data_in_d  = edge_sum_c;
                  data_rdy_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = WAIT_ACK;
               if (frame_done_c) overflow_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         prev_q    <= '0;
         samp_q    <= '0;
         edge_q    <= '0;
         data_in   <= '0;
         data_rdy  <= 1'b0;
         frame_cnt <= '0;
         pop_full  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         samp_q    <= samp_d;
         edge_q    <= edge_d;
         data_in   <= data_in_d;
         data_rdy  <= data_rdy_d;
         frame_cnt <= frame_cnt_d;
         pop_full  <= pop_full_d;
         overflow  <= overflow_d;
      end
   end

endmodule

// File: tb/tb_edge_frame_writer.sv
// Bench for edge_frame_writer: frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_edge_frame_writer;
   localparam int unsigned POPSIZE    = 100;
   localparam int unsigned FRAME_SIZE = 20;
   localparam int unsigned DW         = 8;
   localparam int          THRESH     = 16;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     enable;
   logic [DW-1:0]            sample_in;
   logic                     sample_vld;
   logic [DW-1:0]            data_in;
   logic                     data_rdy;
   logic                     new_data;
   logic [$clog2(POPSIZE):0] frame_cnt;
   logic                     pop_full;
   logic                     overflow;

   edge_frame_writer #(
      .POPSIZE(POPSIZE), .FRAME_SIZE(FRAME_SIZE), .DATA_WIDTH(DW), .EDGE_THRESH(THRESH)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in), .sample_vld(sample_vld),
      .data_in(data_in), .data_rdy(data_rdy), .new_data(new_data), .frame_cnt(frame_cnt),
      .pop_full(pop_full), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int rdy_pulses = 0;

   // Reference model: state expected after the coming rising edge.
   int m_q[$];
   bit m_busy = 1'b0, m_rdy = 1'b0, m_full = 1'b0, m_ovf = 1'b0;
   int m_word = 0, m_cnt = 0;

   task automatic check(input string name, input logic [31:0] got, input int exp);
      n_chk++;
      if (got === 32'(exp)) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   function automatic int count_edges(input int s[$]);
      int n = 0;
      int d;
      for (int i = 1; i < s.size(); i++) begin
         d = s[i] - s[i-1];
         if (d < 0) d = -d;
         if (d >= THRESH && n < (1 << DW) - 1) n++;
      end
      return n;
   endfunction

   task automatic model_step();
      bit done = 1'b0;
      int w = 0;
      m_rdy = 1'b0;
      if (rst) begin
         m_q.delete();
         m_busy = 1'b0; m_full = 1'b0; m_ovf = 1'b0; m_word = 0; m_cnt = 0;
         return;
      end
      if (sample_vld && enable && !m_full) begin
         m_q.push_back(int'(sample_in));
         if (m_q.size() == FRAME_SIZE) begin
            done = 1'b1;
            w = count_edges(m_q);
            m_q.delete();
         end
      end
      if (new_data && m_busy) begin
         m_cnt++;
         m_busy = 1'b0;
         if (m_cnt == POPSIZE) m_full = 1'b1;
      end
      if (done) begin
         if (m_busy) m_ovf = 1'b1;
         else if (!m_full) begin
            m_busy = 1'b1; m_word = w; m_rdy = 1'b1;
         end
      end
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic cyc(input logic r, input logic e, input logic v, input int val, input logic nd);
      rst = r; enable = e; sample_vld = v; sample_in = DW'(val); new_data = nd;
      model_step();
      @(negedge clk);
      check("data_rdy", 32'(data_rdy), int'(m_rdy));
      check("data_in", 32'(data_in), m_word);
      check("frame_cnt", 32'(frame_cnt), m_cnt);
      check("pop_full", 32'(pop_full), int'(m_full));
      check("overflow", 32'(overflow), int'(m_ovf));
      if (data_rdy === 1'b1) rdy_pulses++;
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic idle(input int n, input logic nd);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 0, nd);
   endtask

   task automatic samp(input int val, input logic nd);
      cyc(1'b0, 1'b1, 1'b1, val, nd);
   endtask

   task automatic frame_alt(input int a, input int b, input int n);
      for (int i = 0; i < n; i++) samp((i % 2) ? b : a, 1'b0);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; sample_vld = 1'b0; sample_in = '0; new_data = 1'b0;
      do_reset();
      do_reset();
      check("rst_data_rdy", 32'(data_rdy), 0);
      check("rst_data_in", 32'(data_in), 0);
      check("rst_frame_cnt", 32'(frame_cnt), 0);
      check("rst_pop_full", 32'(pop_full), 0);
      check("rst_overflow", 32'(overflow), 0);

      // Alternating 0/32, ack two cycles after the strobe
      rdy_pulses = 0;
      frame_alt(0, 32, 20);
      check("alt_rdy", 32'(data_rdy), 1);
      check("alt_count", 32'(data_in), 19);
      idle(2, 1'b0);
      check("alt_rdy_low", 32'(data_rdy), 0);
      check("alt_hold", 32'(data_in), 19);
      idle(1, 1'b1);
      check("alt_cnt", 32'(frame_cnt), 1);
      idle(2, 1'b0);
      check("alt_pulses", 32'(rdy_pulses), 1);

      // Steps of exactly 16 (all edges), then steps of 15 (no edges)
      for (int i = 0; i < 20; i++) samp((i < 16) ? i * 16 : (30 - i) * 16, 1'b0);
      check("thr16_count", 32'(data_in), 19);
      idle(1, 1'b1);
      for (int i = 0; i < 20; i++) samp((i < 18) ? i * 15 : 255 - (i - 17) * 15, 1'b0);
      check("thr15_rdy", 32'(data_rdy), 1);
      check("thr15_count", 32'(data_in), 0);
      idle(1, 1'b1);
      check("thr_cnt", 32'(frame_cnt), 3);

      // enable low mid-frame holds counters and previous sample
      frame_alt(0, 40, 10);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 200, 1'b0);
      for (int i = 0; i < 10; i++) samp(40, 1'b0);
      check("hold_count", 32'(data_in), 9);
      idle(1, 1'b1);
      check("hold_cnt", 32'(frame_cnt), 4);

      // Second frame completes while first word is pending: overflow
      do_reset();
      rdy_pulses = 0;
      frame_alt(0, 32, 20);
      idle(1, 1'b0);
      for (int i = 0; i < 20; i++) samp(100, 1'b0);
      check("ovf_flag", 32'(overflow), 1);
      check("ovf_word", 32'(data_in), 19);
      check("ovf_pulses", 32'(rdy_pulses), 1);
      idle(1, 1'b1);
      check("ovf_cnt", 32'(frame_cnt), 1);

      // Second frame completes on the ack cycle: back-to-back send, no overflow
      do_reset();
      frame_alt(0, 32, 20);
      idle(1, 1'b0);
      for (int i = 0; i < 19; i++) samp(i * 10, 1'b0);
      samp(250, 1'b1);
      check("b2b_rdy", 32'(data_rdy), 1);
      check("b2b_count", 32'(data_in), 1);
      check("b2b_ovf", 32'(overflow), 0);
      check("b2b_cnt1", 32'(frame_cnt), 1);
      idle(1, 1'b1);
      check("b2b_cnt2", 32'(frame_cnt), 2);

      // Reset in WAIT_ACK discards pending word and partial frame
      do_reset();
      for (int i = 0; i < 20; i++) samp((i < 8) ? (i % 2) * 50 : 50, 1'b0);
      idle(2, 1'b0);
      check("wa_word", 32'(data_in), 7);
      frame_alt(0, 100, 5);
      do_reset();
      check("wa_rst_word", 32'(data_in), 0);
      check("wa_rst_rdy", 32'(data_rdy), 0);
      check("wa_rst_cnt", 32'(frame_cnt), 0);
      idle(1, 1'b1);
      check("wa_late_ack", 32'(frame_cnt), 0);
      for (int i = 0; i < 15; i++) samp(0, 1'b0);
      check("wa_no_partial", 32'(data_rdy), 0);
      for (int i = 0; i < 5; i++) samp(0, 1'b0);
      check("wa_fresh_rdy", 32'(data_rdy), 1);
      idle(1, 1'b1);

      // Fill the population, then confirm further frames are ignored
      do_reset();
      for (int f = 0; f < int'(POPSIZE); f++) begin
         for (int i = 0; i < 20; i++) samp((i % 2) * (f % 4) * 8, 1'b0);
         if (f == int'(POPSIZE) - 1) check("pop_not_full", 32'(pop_full), 0);
         idle(1, 1'b1);
      end
      check("pop_full", 32'(pop_full), 1);
      check("pop_cnt", 32'(frame_cnt), 100);
      rdy_pulses = 0;
      frame_alt(0, 32, 20);
      idle(3, 1'b0);
      check("pop_no_rdy", 32'(rdy_pulses), 0);
      check("pop_cnt_hold", 32'(frame_cnt), 100);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
